// File: rtl/adder_chk_pkg.sv
// Shared types and golden-sum helper for the 8-bit adder result checker.
// Latency: combinational helper only.
// Backpressure: none; types and functions only.
package adder_chk_pkg;

    localparam int OP_W  = 8;
    localparam int SUM_W = 9;

    typedef logic [SUM_W-1:0] sum_t;
    typedef logic [OP_W-1:0]  op_t;

    // Zero-extend both operands before adding so the carry lands in bit 8.
    function automatic sum_t golden_sum(input op_t a, input op_t b);
        return sum_t'(a) + sum_t'(b);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count and registered head.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: push on full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output T                           head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the simultaneous push writes into.
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = count_q;
    // Head is read from storage before this edge's write, so a full
    // push+pop still returns the old entry.
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/adder_result_checker.sv
// In-line checker: queues golden sums of snooped operands, compares DUT results in order.
// Latency: compare outcome (counters, mismatch, exp/got) registered 1 cycle after data_out_vld.
// Backpressure: none; purely observes, flags overflow/unexpected/timeout as sticky errors.
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     data_in_vld,
    input  op_t                      addend0,
    input  op_t                      addend1,
    input  logic                     data_out_vld,
    input  sum_t                     sum,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     mismatch,
    output sum_t                     exp_sum,
    output sum_t                     got_sum,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_unexp,
    output logic                     err_ovf,
    output logic                     err_timeout
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    sum_t             golden;
    sum_t             head;
    logic             q_full, q_empty;
    logic [OCC_W-1:0] q_count;
    logic             do_pop, unexp_evt, ovf_evt, age_hit;

    logic [AGE_W-1:0] age_q, age_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic             mis_q, mis_d;
    sum_t             exp_q, exp_d, got_q, got_d;
    logic             unexp_q, unexp_d, ovf_q, ovf_d, to_q, to_d;

    assign golden    = golden_sum(addend0, addend1);
    // Occupancy is sampled before the edge, so a same-cycle push can never
    // satisfy a same-cycle result.
    assign do_pop    = data_out_vld && !q_empty;
    assign unexp_evt = data_out_vld && q_empty;
    assign ovf_evt   = data_in_vld && q_full && !do_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (sum_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (data_in_vld),
        .data_i  (golden),
        .pop_i   (data_out_vld),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count),
        .head_o  (head)
    );

    // Head age: restarts on every pop and while empty, then holds at TIMEOUT.
    always_comb begin
        age_d = age_q;
        if (do_pop || q_empty) begin
            age_d = '0;
        end else if (age_q != AGE_W'(TIMEOUT)) begin
            age_d = age_q + 1'b1;
        end
    end

    assign age_hit = (age_d == AGE_W'(TIMEOUT));

    // Compare, saturating counters and sticky flags; clr overrides any event.
    always_comb begin
        pass_d  = pass_q;
        fail_d  = fail_q;
        mis_d   = 1'b0;
        exp_d   = exp_q;
        got_d   = got_q;
        unexp_d = unexp_q;
        ovf_d   = ovf_q;
        to_d    = to_q;
        if (clr) begin
            pass_d  = '0;
            fail_d  = '0;
            exp_d   = '0;
            got_d   = '0;
            unexp_d = 1'b0;
            ovf_d   = 1'b0;
            to_d    = 1'b0;
        end else begin
            if (do_pop) begin
                if (head == sum) begin
                    if (pass_q != '1) pass_d = pass_q + 1'b1;
                end else begin
                    if (fail_q != '1) fail_d = fail_q + 1'b1;
                    mis_d = 1'b1;
                    exp_d = head;
                    got_d = sum;
                end
            end
            if (unexp_evt) unexp_d = 1'b1;
            if (ovf_evt)   ovf_d   = 1'b1;
            if (age_hit)   to_d    = 1'b1;
        end
    end

    // Checker state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            mis_q   <= 1'b0;
            exp_q   <= '0;
            got_q   <= '0;
            unexp_q <= 1'b0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            age_q   <= age_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            mis_q   <= mis_d;
            exp_q   <= exp_d;
            got_q   <= got_d;
            unexp_q <= unexp_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign mismatch    = mis_q;
    assign exp_sum     = exp_q;
    assign got_sum     = got_q;
    assign outstanding = q_count;
    assign err_unexp   = unexp_q;
    assign err_ovf     = ovf_q;
    assign err_timeout = to_q;

endmodule
